// File: rtl/sent_pkg.sv
// Shared SENT definitions: FSM states, period constants and the CRC-4 lookup.
// Also used by the receiver-side CRC check.
package sent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_STATUS,
        ST_DATA,
        ST_CRC,
        ST_PAUSE,
        ST_END
    } sent_state_t;

    localparam int SYNC_TICKS        = 56;
    localparam int NIBBLE_BASE_TICKS = 12;
    localparam int PAUSE_MIN_TICKS   = 12;

    localparam logic [3:0] CRC_SEED = 4'h5;

    // T[x] = x * 2^4 mod (x^4+x^3+x^2+1); entry 0 sits in the low nibble.
    localparam logic [15:0][3:0] CRC4_TABLE = 64'h582F_B6C1_493E_A7D0;

    function automatic logic [2:0] clamp_count(input logic [2:0] n);
        logic [2:0] r;
        r = n;
        if (n == 3'd0) r = 3'd1;
        if (n == 3'd7) r = 3'd6;
        return r;
    endfunction

    function automatic logic [9:0] clamp_pause(input logic [9:0] p);
        logic [9:0] r;
        r = p;
        if (p != 10'd0 && p < 10'(PAUSE_MIN_TICKS)) r = 10'(PAUSE_MIN_TICKS);
        return r;
    endfunction

endpackage

// File: rtl/sent_crc4_step.sv
// One SENT CRC-4 step: crc_out = T[crc_in] ^ nibble (purely combinational).
module sent_crc4_step
    import sent_pkg::*;
(
    input  logic [3:0] i_crc,
    input  logic [3:0] i_nibble,
    output logic [3:0] o_crc
);

    assign o_crc = CRC4_TABLE[i_crc] ^ i_nibble;

endmodule

// File: rtl/sent_tx_pulse_gen.sv
// SENT transmitter: latches a frame descriptor and drives sync/status/data/CRC/pause
// periods on a single open line, chaining frames back-to-back when one is waiting.
module sent_tx_pulse_gen
    import sent_pkg::*;
#(
    parameter int TICK_CLKS = 6,
    parameter int LOW_TICKS = 5
) (
    input  logic        clk_tx,
    input  logic        reset_n_tx,
    input  logic        frame_valid_i,
    output logic        frame_ready_o,
    input  logic [3:0]  status_i,
    input  logic [23:0] data_i,
    input  logic [2:0]  nibble_count_i,
    input  logic [9:0]  pause_ticks_i,
    output logic        sent_tx_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [3:0]  crc_o
);

    localparam int TW = $clog2(TICK_CLKS);

    sent_state_t  r_state;
    logic [TW-1:0] r_tick_cnt;
    logic [9:0]   r_pcnt;
    logic [3:0]   r_status;
    logic [23:0]  r_data;
    logic [2:0]   r_left;
    logic [9:0]   r_pause;
    logic [3:0]   r_crc;
    logic         r_tx, r_busy, r_done, r_rdy_en;

    logic         w_tick, w_last, w_final, w_accept;
    logic [9:0]   w_len;
    logic [3:0]   w_step_nib, w_crc_next;
    logic [2:0]   w_cnt;
    logic [23:0]  w_data_aligned;

    assign w_tick = (r_tick_cnt == TW'(TICK_CLKS - 1));

    always_comb begin
        w_len = 10'(LOW_TICKS);
        case (r_state)
            ST_SYNC:   w_len = 10'(SYNC_TICKS);
            ST_STATUS: w_len = 10'(NIBBLE_BASE_TICKS) + 10'(r_status);
            ST_DATA:   w_len = 10'(NIBBLE_BASE_TICKS) + 10'(r_data[23:20]);
            ST_CRC:    w_len = 10'(NIBBLE_BASE_TICKS) + 10'(r_crc);
            ST_PAUSE:  w_len = r_pause;
            default:   w_len = 10'(LOW_TICKS);
        endcase
    end

    assign w_last  = w_tick && (r_pcnt == w_len - 10'd1);
    assign w_final = w_last && (r_state == ST_PAUSE || (r_state == ST_CRC && r_pause == 10'd0));

    // Ready only in IDLE or on the very last tick of a frame, so a waiting frame chains without a gap.
    assign frame_ready_o = r_rdy_en && (r_state == ST_IDLE || w_final);
    assign w_accept      = frame_valid_i && frame_ready_o;

    // Nibble folded into the CRC at the edge that starts the next data period; 0 gives the augment step.
    always_comb begin
        w_step_nib = 4'h0;
        if (r_state == ST_STATUS)
            w_step_nib = r_data[23:20];
        else if (r_state == ST_DATA && r_left != 3'd0)
            w_step_nib = r_data[19:16];
    end

    sent_crc4_step u_crc_step (
        .i_crc    (r_crc),
        .i_nibble (w_step_nib),
        .o_crc    (w_crc_next)
    );

    assign w_cnt          = clamp_count(nibble_count_i);
    assign w_data_aligned = data_i << {3'd6 - w_cnt, 2'b00};

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_pcnt     <= '0;
            r_status   <= '0;
            r_data     <= '0;
            r_left     <= '0;
            r_pause    <= '0;
            r_crc      <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rdy_en   <= 1'b0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_done     <= w_final;
            r_tick_cnt <= (w_accept || w_tick) ? '0 : r_tick_cnt + 1'b1;
            r_tx       <= !(r_state != ST_IDLE && r_pcnt < 10'(LOW_TICKS));
            if (w_accept) begin
                r_state  <= ST_SYNC;
                r_pcnt   <= '0;
                r_status <= status_i;
                r_data   <= w_data_aligned;
                r_left   <= w_cnt - 3'd1;
                r_pause  <= clamp_pause(pause_ticks_i);
                r_busy   <= 1'b1;
            end else if (r_state != ST_IDLE && w_tick) begin
                if (w_last) begin
                    r_pcnt <= '0;
                    case (r_state)
                        ST_SYNC: begin
                            r_state <= ST_STATUS;
                            r_crc   <= CRC_SEED;
                        end
                        ST_STATUS: begin
                            r_state <= ST_DATA;
                            r_crc   <= w_crc_next;
                        end
                        ST_DATA: begin
                            r_crc <= w_crc_next;
                            if (r_left != 3'd0) begin
                                r_left <= r_left - 3'd1;
                                r_data <= r_data << 4;
                            end else begin
                                r_state <= ST_CRC;
                            end
                        end
                        ST_CRC:   r_state <= (r_pause != 10'd0) ? ST_PAUSE : ST_END;
                        ST_PAUSE: r_state <= ST_END;
                        default: begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end else begin
                    r_pcnt <= r_pcnt + 10'd1;
                end
            end
        end
    end

    assign sent_tx_o    = r_tx;
    assign busy_o       = r_busy;
    assign frame_done_o = r_done;
    assign crc_o        = r_crc;

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// Bench for sent_tx_pulse_gen: expected period lengths and CRCs are queued when a frame
// is driven, and checked against measured falling-edge intervals on the line.
module tb_sent_tx_pulse_gen;

    localparam int TICK = 6;
    localparam int LOW  = 5;
    localparam int SYNC = 56;

    logic        clk_tx = 1'b0;
    logic        reset_n_tx = 1'b0;
    logic        frame_valid_i = 1'b0;
    logic [3:0]  status_i = '0;
    logic [23:0] data_i = '0;
    logic [2:0]  nibble_count_i = '0;
    logic [9:0]  pause_ticks_i = '0;
    logic        frame_ready_o, sent_tx_o, busy_o, frame_done_o;
    logic [3:0]  crc_o;

    sent_tx_pulse_gen #(.TICK_CLKS(TICK), .LOW_TICKS(LOW)) dut (
        .clk_tx         (clk_tx),
        .reset_n_tx     (reset_n_tx),
        .frame_valid_i  (frame_valid_i),
        .frame_ready_o  (frame_ready_o),
        .status_i       (status_i),
        .data_i         (data_i),
        .nibble_count_i (nibble_count_i),
        .pause_ticks_i  (pause_ticks_i),
        .sent_tx_o      (sent_tx_o),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o),
        .crc_o          (crc_o)
    );

    always #5 clk_tx = ~clk_tx;

    int n_cmp = 0, n_bad = 0;
    int exp_q[$];
    logic [3:0] crc_q[$];
    int cyc = 0, t_fall = 0, done_cyc = -10, pend = 0, n_done = 0, n_acc = 0;
    bit have_pend = 0;
    logic prev_tx = 1'b1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Multiply by x^4 modulo x^4+x^3+x^2+1, one shift at a time.
    function automatic logic [3:0] mul16(input logic [3:0] v);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < 4; i++) r = {r[2:0], 1'b0} ^ (r[3] ? 4'hD : 4'h0);
        return r;
    endfunction

    function automatic logic [3:0] crc_model(input logic [23:0] d, input int nn);
        logic [3:0] c;
        logic [23:0] s;
        c = 4'h5;
        for (int i = 0; i < nn; i++) begin
            s = d >> (4 * (nn - 1 - i));
            c = mul16(c) ^ s[3:0];
        end
        return mul16(c);
    endfunction

    // Line monitor: a period runs from one falling edge to the next. Entry 0 marks the
    // closing pulse, a negative entry marks a chained sync; both must follow frame_done.
    initial forever begin
        @(negedge clk_tx);
        cyc++;
        if (!reset_n_tx) begin
            have_pend = 0;
            prev_tx = 1'b1;
        end else begin
            if (frame_valid_i && frame_ready_o) n_acc++;
            if (frame_done_o) begin
                n_done++;
                done_cyc = cyc;
                chk("done_expected", crc_q.size() > 0, 1);
                if (crc_q.size() > 0) chk("crc_o", crc_o, crc_q.pop_front());
            end
            if (prev_tx && !sent_tx_o) begin
                if (have_pend && pend > 0) chk("period_clks", cyc - t_fall, pend * TICK);
                chk("fall_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    pend = exp_q.pop_front();
                    have_pend = 1;
                    if (pend <= 0) chk("done_before_edge", done_cyc, cyc - 1);
                    if (pend < 0) pend = -pend;
                end else begin
                    have_pend = 0;
                end
                t_fall = cyc;
            end else if (!prev_tx && sent_tx_o && have_pend) begin
                chk("low_width_clks", cyc - t_fall, LOW * TICK);
            end
            prev_tx = sent_tx_o;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive(input logic [3:0] st, input logic [23:0] d, input logic [2:0] n,
                         input logic [9:0] p, input bit b2b, input bit fin);
        int nn, pp;
        logic [3:0] c;
        logic [23:0] s;
        bit acc;
        nn = (n == 3'd0) ? 1 : ((n == 3'd7) ? 6 : int'(n));
        pp = (p == 10'd0) ? 0 : ((p < 10'd12) ? 12 : int'(p));
        exp_q.push_back(b2b ? -SYNC : SYNC);
        exp_q.push_back(12 + int'(st));
        for (int i = 0; i < nn; i++) begin
            s = d >> (4 * (nn - 1 - i));
            exp_q.push_back(12 + int'(s[3:0]));
        end
        c = crc_model(d, nn);
        exp_q.push_back(12 + int'(c));
        if (pp > 0) exp_q.push_back(pp);
        if (fin) exp_q.push_back(0);
        crc_q.push_back(c);
        frame_valid_i = 1'b1;
        status_i = st;
        data_i = d;
        nibble_count_i = n;
        pause_ticks_i = p;
        acc = 0;
        for (int i = 0; i < 20000 && !acc; i++) begin
            if (frame_ready_o) acc = 1;
            @(posedge clk_tx);
            #1;
        end
        chk("accepted", acc, 1);
        if (acc) chk("busy_after_accept", busy_o, 1);
        if (fin) frame_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 20000 && !idle; i++) begin
            if (!busy_o) idle = 1;
            else begin
                @(posedge clk_tx);
                #1;
            end
        end
        chk("busy_drops", idle, 1);
        repeat (3) begin
            @(posedge clk_tx);
            #1;
        end
        chk("idle_line_high", sent_tx_o, 1);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int d0, a0;
        repeat (3) @(posedge clk_tx);
        #1;
        chk("rst_tx", sent_tx_o, 1);
        chk("rst_ready", frame_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", frame_done_o, 0);
        chk("rst_crc", crc_o, 0);
        reset_n_tx = 1'b1;
        @(posedge clk_tx);
        #1;
        chk("ready_after_release", frame_ready_o, 1);

        // all-zero payload, six nibbles, no pause
        drive(4'h0, 24'h000000, 3'd6, 10'd0, 0, 1);
        wait_idle();

        // three nibbles with a 100-tick pause
        d0 = n_done;
        drive(4'h3, 24'h000ABC, 3'd3, 10'd100, 0, 1);
        wait_idle();
        chk("done_once_pause", n_done - d0, 1);

        // three chained frames with valid held high
        d0 = n_done;
        a0 = n_acc;
        drive(4'h1, 24'h123456, 3'd6, 10'd0, 0, 0);
        drive(4'h2, 24'h00FEDC, 3'd4, 10'd20, 1, 0);
        drive(4'h5, 24'h000007, 3'd1, 10'd0, 1, 1);
        wait_idle();
        chk("b2b_ready_pulses", n_acc - a0, 3);
        chk("b2b_done_count", n_done - d0, 3);

        // clamps: count 0 -> 1 nibble, short pause -> 12, count 7 -> 6 nibbles
        drive(4'hF, 24'h000009, 3'd0, 10'd5, 0, 1);
        wait_idle();
        drive(4'hA, 24'h9ABCDE, 3'd7, 10'd11, 0, 1);
        wait_idle();

        // reset in the middle of the third data nibble (low phase)
        drive(4'h0, 24'h000000, 3'd6, 10'd0, 0, 1);
        repeat (569) @(posedge clk_tx);
        #2;
        chk("pre_reset_low", sent_tx_o, 0);
        reset_n_tx = 1'b0;
        #1;
        chk("async_rst_tx", sent_tx_o, 1);
        chk("async_rst_busy", busy_o, 0);
        chk("async_rst_crc", crc_o, 0);
        exp_q.delete();
        crc_q.delete();
        repeat (2) @(posedge clk_tx);
        #1;
        reset_n_tx = 1'b1;
        @(posedge clk_tx);
        #1;
        drive(4'h6, 24'h00A5C3, 3'd4, 10'd0, 0, 1);
        wait_idle();

        for (int k = 0; k < 4; k++) begin
            drive(4'($urandom_range(0, 15)), 24'($urandom), 3'($urandom_range(0, 7)),
                  10'($urandom_range(0, 40)), 0, 1);
            wait_idle();
        end

        chk("periods_drained", exp_q.size(), 0);
        chk("crcs_drained", crc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
